gpio_in_cond: RTL and testbench
===============================

GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable cycles needed to accept a new filtered level (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port gpio_pad, input, 32 bits: raw, asynchronous pin levels.
REQ-005 SHALL have port gpio_in, output, 32 bits: conditioned levels, driven to the GPIO core's gpio_in.
REQ-006 SHALL have port wr_en, input, 1 bit: register write strobe.
REQ-007 SHALL have port rd_en, input, 1 bit: register read strobe.
REQ-008 SHALL have port addr, input, 8 bits: register byte address.
REQ-009 SHALL have port wdata, input, 32 bits: write data.
REQ-010 SHALL have port rdata, output, 32 bits: read data.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-012 SHALL pass each gpio_pad bit through a 2-flop synchronizer (sync2) before any other use.
REQ-013 SHALL keep one saturating counter per bit: cleared when sync2 equals filt; incremented when they differ.
REQ-014 SHALL, when a differing bit has been seen for DB_CYCLES consecutive cycles, load sync2 into filt on that edge and clear the counter; gpio_in = filt.
REQ-015 SHALL make gpio_in follow a stable pad change exactly 2+DB_CYCLES cycles after the first sampling edge; any glitch shorter than DB_CYCLES cycles (post-sync) SHALL leave gpio_in unchanged.
REQ-016 SHALL detect a rise as a filt 0->1 update and a fall as a filt 1->0 update, per bit, in the same cycle filt changes.
REQ-017 SHALL provide register map: 0x00 FILT (RO, = filt); 0x04 RISE_EN (RW); 0x08 FALL_EN (RW); 0x0C IRQ_STAT (R, write-1-to-clear); 0x10 IRQ_MASK (RW).
REQ-018 SHALL set IRQ_STAT[i] on the cycle after a qualified event: (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
REQ-019 SHALL give set priority over clear: a set and a W1C on the same bit in the same cycle SHALL leave it 1.
REQ-020 SHALL register irq = |(IRQ_STAT & IRQ_MASK), so it lags a status change by one cycle.
REQ-021 SHALL make reads combinational: rdata = selected register when rd_en=1 and addr is mapped, else 32'h0.
REQ-022 SHALL ignore writes to 0x00 and to unmapped addresses; a read of 0x0C SHALL not clear status.

Reset
REQ-023 SHALL, while rst=1, clear sync stages, counters, filt, gpio_in, RISE_EN, FALL_EN, IRQ_STAT, IRQ_MASK and irq to 0.
REQ-024 SHALL abort in-progress debounce counts on reset, generate no edge event on reset entry or exit, and begin counting at the first edge after rst falls.

Configuration
REQ-025 SHALL compile the debounce counters only when GPIO_IN_DEBOUNCE_EN is defined.
REQ-026 SHALL, without GPIO_IN_DEBOUNCE_EN, set filt = sync2 delayed one register, giving a fixed latency of 3 cycles with no glitch rejection; DB_CYCLES is then ignored and edges are detected on that register.

Verification (DB_CYCLES=4, debounce enabled unless noted)
REQ-027 SHALL test: pad[0] 0->1 held -> gpio_in[0]=1 exactly 6 cycles later; FILT reads 32'h1.
REQ-028 SHALL test: pad[3] high for 3 cycles then low -> gpio_in[3] stays 0 and IRQ_STAT stays 0.
REQ-029 SHALL test: RISE_EN=1, IRQ_MASK=1, pad[0] rises -> IRQ_STAT=32'h1 and irq=1 one cycle later; write 0x0C=32'h1 -> irq=0 after two cycles.
REQ-030 SHALL test: a W1C of bit 5 coincident with a bit-5 fall (FALL_EN[5]=1) -> IRQ_STAT[5] remains 1.
REQ-031 SHALL test: assert rst mid-count (counter=2) -> all outputs 0; after release a stable pad needs a full 6 cycles to appear.
REQ-032 SHALL test: without GPIO_IN_DEBOUNCE_EN, a 1-cycle pad pulse -> gpio_in pulses for 1 cycle, 3 cycles later; an unmapped read (addr 0x14) returns 32'h0.

Source files
------------

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: 2-flop synchronizer, optional per-bit debounce, edge detect and IRQ registers.
// Define GPIO_IN_DEBOUNCE_EN to build the debounce counters; otherwise filt is sync2 delayed one register.
module gpio_in_cond #(
    parameter int DB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_pad,
    output logic [31:0] gpio_in,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [7:0] ADDR_FILT     = 8'h00;
    localparam logic [7:0] ADDR_RISE_EN  = 8'h04;
    localparam logic [7:0] ADDR_FALL_EN  = 8'h08;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h10;

    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] filt;
    logic [31:0] filt_nxt;
    logic [31:0] rise_q;
    logic [31:0] fall_q;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] irq_stat;
    logic [31:0] irq_mask;
    logic [31:0] stat_set;
    logic [31:0] stat_clr;

`ifdef GPIO_IN_DEBOUNCE_EN
    // A bit loads on the DB_CYCLES-th consecutive cycle that sync2 differs from filt.
    localparam logic [3:0] CNT_LAST = 4'(DB_CYCLES - 1);

    logic [3:0] cnt [32];

    always_comb begin
        filt_nxt = filt;
        for (int i = 0; i < 32; i++) begin
            if ((sync2[i] != filt[i]) && (cnt[i] == CNT_LAST)) begin
                filt_nxt[i] = sync2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if ((sync2[i] == filt[i]) || (cnt[i] == CNT_LAST)) begin
                    cnt[i] <= 4'h0;
                end else if (cnt[i] != 4'hF) begin
                    cnt[i] <= cnt[i] + 4'h1;
                end
            end
        end
    end
`else
    logic [3:0] unused_db_cycles;

    assign unused_db_cycles = 4'(DB_CYCLES);
    assign filt_nxt         = sync2;
`endif

    // wr_en/rd_en are single-cycle strobes qualified by addr; writes take effect on the
    // next rising edge, reads are combinational and return zero when not selected.
    assign stat_set = (rise_q & rise_en) | (fall_q & fall_en);
    assign stat_clr = (wr_en && (addr == ADDR_IRQ_STAT)) ? wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 32'h0;
            sync2    <= 32'h0;
            filt     <= 32'h0;
            rise_q   <= 32'h0;
            fall_q   <= 32'h0;
            rise_en  <= 32'h0;
            fall_en  <= 32'h0;
            irq_stat <= 32'h0;
            irq_mask <= 32'h0;
            irq      <= 1'b0;
        end else begin
            sync1    <= gpio_pad;
            sync2    <= sync1;
            filt     <= filt_nxt;
            rise_q   <= filt_nxt & ~filt;
            fall_q   <= ~filt_nxt & filt;
            // Set wins over a same-cycle W1C on the same bit.
            irq_stat <= (irq_stat & ~stat_clr) | stat_set;
            irq      <= |(irq_stat & irq_mask);
            if (wr_en && (addr == ADDR_RISE_EN)) begin
                rise_en <= wdata;
            end
            if (wr_en && (addr == ADDR_FALL_EN)) begin
                fall_en <= wdata;
            end
            if (wr_en && (addr == ADDR_IRQ_MASK)) begin
                irq_mask <= wdata;
            end
        end
    end

    assign gpio_in = filt;

    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (addr)
                ADDR_FILT:     rdata = filt;
                ADDR_RISE_EN:  rdata = rise_en;
                ADDR_FALL_EN:  rdata = fall_en;
                ADDR_IRQ_STAT: rdata = irq_stat;
                ADDR_IRQ_MASK: rdata = irq_mask;
                default:       rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed stimulus, expected values queued at issue time, monitors compare.
module tb_gpio_in_cond;

    localparam int DB = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] gpio_pad;
    logic [31:0] gpio_in;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    gpio_in_cond #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_pad (gpio_pad),
        .gpio_in  (gpio_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic        irq_exp_q[$];
    int          irq_cyc_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [31:0] last_gpio = 32'h0;
    logic        last_irq  = 1'b0;

    always @(negedge clk) begin : gpio_mon
        logic [31:0] e;
        int          c;
        if (gpio_in !== last_gpio) begin
            if (exp_q.size() == 0) begin
                check("gpio_unexpected_change", gpio_in, last_gpio);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("gpio_value", gpio_in, e);
                check("gpio_cycle", 32'(cyc), 32'(c));
            end
            last_gpio = gpio_in;
        end
    end

    always @(negedge clk) begin : irq_mon
        logic e;
        int   c;
        if (irq !== last_irq) begin
            if (irq_exp_q.size() == 0) begin
                check("irq_unexpected_change", {31'b0, irq}, {31'b0, last_irq});
            end else begin
                e = irq_exp_q.pop_front();
                c = irq_cyc_q.pop_front();
                check("irq_value", {31'b0, irq}, {31'b0, e});
                check("irq_cycle", 32'(cyc), 32'(c));
            end
            last_irq = irq;
        end
    end

    always @(negedge clk) begin : rd_mon
        logic [31:0] e;
        string       n;
        if (rd_en) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", rdata, 32'h0);
            end else begin
                e = rd_exp_q.pop_front();
                n = rd_name_q.pop_front();
                check(n, rdata, e);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step();
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string n, input logic [7:0] a, input logic [31:0] e);
        step();
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        rd_en = 1'b1;
        addr  = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic expect_gpio(input logic [31:0] v, input int c);
        exp_q.push_back(v);
        exp_cyc_q.push_back(c);
    endtask

    task automatic expect_irq(input logic v, input int c);
        irq_exp_q.push_back(v);
        irq_cyc_q.push_back(c);
    endtask

    int c;
    int w;
    int m;
    int r;

    initial begin
        rst      = 1'b1;
        gpio_pad = 32'h0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        addr     = 8'h0;
        wdata    = 32'h0;
        repeat (3) step();
        check("rst_gpio_in", gpio_in, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;

        rd("rst_filt", 8'h00, 32'h0);
        rd("rst_rise_en", 8'h04, 32'h0);
        rd("rst_fall_en", 8'h08, 32'h0);
        rd("rst_irq_stat", 8'h0C, 32'h0);
        rd("rst_irq_mask", 8'h10, 32'h0);

        wr(8'h04, 32'h1);
        wr(8'h10, 32'h1);
        wr(8'h08, 32'h20);
        rd("rise_en_rw", 8'h04, 32'h1);
        rd("irq_mask_rw", 8'h10, 32'h1);
        rd("fall_en_rw", 8'h08, 32'h20);
        addr = 8'h08;
        #1;
        check("rdata_without_rd_en", rdata, 32'h0);

        wr(8'h00, 32'hFFFF_FFFF);
        wr(8'h14, 32'hFFFF_FFFF);
        rd("filt_write_ignored", 8'h00, 32'h0);
        rd("unmapped_read", 8'h14, 32'h0);
        rd("rise_en_after_unmapped_wr", 8'h04, 32'h1);

        // rising edge on bit 0 with interrupt, then W1C
        step();
        gpio_pad = 32'h1;
        c = cyc;
        expect_gpio(32'h1, c + LAT);
        expect_irq(1'b1, c + LAT + 2);
        wait_to(c + LAT + 3);
        rd("filt_after_rise", 8'h00, 32'h1);
        rd("stat_after_rise", 8'h0C, 32'h1);
        w = cyc + 1;
        expect_irq(1'b0, w + 2);
        wr(8'h0C, 32'h1);
        wait_to(w + 3);
        rd("stat_after_w1c", 8'h0C, 32'h0);

        // short pulse on bit 3
        wr(8'h04, 32'h9);
        wr(8'h08, 32'h28);
        step();
        gpio_pad = 32'h9;
        c = cyc;
`ifdef GPIO_IN_DEBOUNCE_EN
        repeat (3) step();
        gpio_pad = 32'h1;
        wait_to(c + 12);
        rd("filt_glitch_rejected", 8'h00, 32'h1);
        rd("stat_glitch_rejected", 8'h0C, 32'h0);
`else
        expect_gpio(32'h9, c + 3);
        expect_gpio(32'h1, c + 4);
        step();
        gpio_pad = 32'h1;
        wait_to(c + 8);
        rd("filt_after_pulse", 8'h00, 32'h1);
        rd("stat_after_pulse", 8'h0C, 32'h8);
        wr(8'h0C, 32'h8);
        rd("stat_pulse_cleared", 8'h0C, 32'h0);
`endif

        // bit 5: rise (not enabled), then fall coincident with W1C
        step();
        gpio_pad = 32'h21;
        c = cyc;
        expect_gpio(32'h21, c + LAT);
        wait_to(c + LAT + 3);
        rd("stat_rise5_not_enabled", 8'h0C, 32'h0);
        step();
        gpio_pad = 32'h1;
        c = cyc;
        expect_gpio(32'h1, c + LAT);
        wait_to(c + LAT - 1);
        wr(8'h0C, 32'h20);
        rd("stat_set_beats_w1c", 8'h0C, 32'h20);
        m = cyc + 1;
        expect_irq(1'b1, m + 2);
        wr(8'h10, 32'h21);
        wait_to(m + 3);

        // reset in the middle of a debounce count
        step();
        gpio_pad = 32'h81;
        c = cyc;
`ifndef GPIO_IN_DEBOUNCE_EN
        expect_gpio(32'h81, c + 3);
`endif
        expect_gpio(32'h0, c + 5);
        expect_irq(1'b0, c + 5);
        wait_to(c + 4);
        rst = 1'b1;
        step();
        check("midreset_gpio_in", gpio_in, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        step();
        rst = 1'b0;
        r = cyc;
        expect_gpio(32'h81, r + LAT);
        wr(8'h04, 32'h81);
        rd("mask_after_reset", 8'h10, 32'h0);
        rd("fall_en_after_reset", 8'h08, 32'h0);
        wait_to(r + LAT + 3);
        rd("filt_after_reset", 8'h00, 32'h81);
        rd("stat_after_reset", 8'h0C, 32'h81);

        repeat (6) step();
        check("gpio_queue_drained", 32'(exp_q.size()), 32'h0);
        check("irq_queue_drained", 32'(irq_exp_q.size()), 32'h0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
